// File: rtl/sram_access_sequencer_pkg.sv
// Shared types and helpers for the SRAM access sequencer: state encoding,
// default phase lengths and the bank-select priority function.
package sram_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam int DEF_SETUP_CYCLES = 1;
  localparam int DEF_PULSE_CYCLES = 2;
  localparam int DEF_HOLD_CYCLES  = 1;
  localparam int DEF_CNT_WIDTH    = 4;

  // Scanning downwards leaves the lowest set index as the final answer.
  function automatic logic [4:0] lowest_set_bit(input logic [31:0] vec);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 5'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/sram_access_sequencer_phase_counter.sv
// Loadable down-counter shared by the setup, pulse and hold phases;
// terminal count is flagged while the count sits at zero.
module sram_phase_counter #(
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [CNT_WIDTH-1:0] load_val_i,
  output logic                 tc_o
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  // Next count: load wins, otherwise decrement and rest at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != {CNT_WIDTH{1'b0}}) begin
      count_d = count_q - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= {CNT_WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == {CNT_WIDTH{1'b0}});

endmodule

// File: rtl/sram_access_sequencer.sv
// Turns a one-cycle decoder request into a timed asynchronous-SRAM cycle
// (setup / strobe / hold) with registered pins, read capture and CPU stretch.
module sram_access_sequencer
  import sram_seq_pkg::*;
#(
  parameter int ADDR_WIDTH   = 15,
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_BANKS    = 2,
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req,
  input  logic [NUM_BANKS-1:0]  i_sel,
  input  logic                  i_RW,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [DATA_WIDTH-1:0] i_dq,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_dq,
  output logic                  o_dq_oe,
  output logic                  o_WE,
  output logic                  o_RE,
  output logic [NUM_BANKS-1:0]  o_CE,
  output logic [NUM_BANKS-1:0]  o_CE2,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_MRDY,
  output logic                  o_overrun
);

  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SETUP = SETUP;
  localparam logic [1:0] ST_PULSE = PULSE;
  localparam logic [1:0] ST_HOLD  = HOLD;

  // A phase of N cycles starts the counter at N-1 and leaves on terminal count.
  localparam logic [CNT_WIDTH-1:0] S_LOAD = CNT_WIDTH'((SETUP_CYCLES > 0) ? SETUP_CYCLES - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] P_LOAD = CNT_WIDTH'((PULSE_CYCLES > 0) ? PULSE_CYCLES - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] H_LOAD = CNT_WIDTH'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  logic [1:0]            state_q, state_d;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BANK_W-1:0]     bank_q, bank_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [NUM_BANKS-1:0]  ce_q, ce_d;
  logic [NUM_BANKS-1:0]  ce2_q, ce2_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;
  logic                  dq_oe_q, dq_oe_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  mrdy_q, mrdy_d;
  logic                  overrun_q, overrun_d;

  logic                  accept_s;
  logic                  load_s;
  logic [CNT_WIDTH-1:0]  load_val_s;
  logic                  tc_s;
  logic                  pulse_s;

  assign accept_s = (state_q == ST_IDLE) && i_req && (i_sel != {NUM_BANKS{1'b0}});

  sram_phase_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_phase_cnt (
    .clk_i      (i_clk),
    .rst_i      (i_reset),
    .load_i     (load_s),
    .load_val_i (load_val_s),
    .tc_o       (tc_s)
  );

  // Phase sequencing and counter reload on each phase entry.
  always_comb begin
    state_d    = state_q;
    load_s     = 1'b0;
    load_val_s = {CNT_WIDTH{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          load_s = 1'b1;
          if (SETUP_CYCLES > 0) begin
            state_d    = ST_SETUP;
            load_val_s = S_LOAD;
          end else begin
            state_d    = ST_PULSE;
            load_val_s = P_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (tc_s) begin
          state_d    = ST_PULSE;
          load_s     = 1'b1;
          load_val_s = P_LOAD;
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_PULSE: begin
        if (tc_s) begin
          if (HOLD_CYCLES > 0) begin
            state_d    = ST_HOLD;
            load_s     = 1'b1;
            load_val_s = H_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_PULSE;
        end
      end
      ST_HOLD: begin
        if (tc_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Access attributes are frozen at acceptance and ignore later input changes.
  always_comb begin
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    bank_d  = bank_q;
    if (accept_s) begin
      rw_d    = i_RW;
      addr_d  = i_addr;
      wdata_d = i_wdata;
      bank_d  = BANK_W'(lowest_set_bit(32'(i_sel)));
    end else begin
      rw_d    = rw_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      bank_d  = bank_q;
    end
  end

  // Pin and status values are decoded from the next state so every output is a flop.
  always_comb begin
    busy_d  = (state_d != ST_IDLE);
    pulse_s = (state_d == ST_PULSE);
    for (int b = 0; b < NUM_BANKS; b++) begin
      ce_d[b] = ~(busy_d && (bank_d == BANK_W'(b)));
    end
    ce2_d     = ~ce_d;
    we_d      = ~(pulse_s && !rw_d);
    re_d      = ~(pulse_s && rw_d);
    dq_oe_d   = busy_d && !rw_d;
    done_d    = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    mrdy_d    = ~busy_d;
    overrun_d = (state_q != ST_IDLE) && i_req;
  end

  // Read data is sampled on the edge that closes the final strobe cycle.
  always_comb begin
    rdata_d = rdata_q;
    if ((state_q == ST_PULSE) && tc_s && rw_q) begin
      rdata_d = i_dq;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State, latched access and output registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      rw_q      <= 1'b1;
      addr_q    <= {ADDR_WIDTH{1'b0}};
      wdata_q   <= {DATA_WIDTH{1'b0}};
      bank_q    <= {BANK_W{1'b0}};
      rdata_q   <= {DATA_WIDTH{1'b0}};
      ce_q      <= {NUM_BANKS{1'b1}};
      ce2_q     <= {NUM_BANKS{1'b0}};
      we_q      <= 1'b1;
      re_q      <= 1'b1;
      dq_oe_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mrdy_q    <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      bank_q    <= bank_d;
      rdata_q   <= rdata_d;
      ce_q      <= ce_d;
      ce2_q     <= ce2_d;
      we_q      <= we_d;
      re_q      <= re_d;
      dq_oe_q   <= dq_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mrdy_q    <= mrdy_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_addr    = addr_q;
  assign o_dq      = wdata_q;
  assign o_dq_oe   = dq_oe_q;
  assign o_WE      = we_q;
  assign o_RE      = re_q;
  assign o_CE      = ce_q;
  assign o_CE2     = ce2_q;
  assign o_rdata   = rdata_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_MRDY    = mrdy_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Directed bench for sram_access_sequencer: a default-timing instance and a
// minimal-timing instance (S=0, P=1, H=0) checked cycle by cycle.
module tb_sram_access_sequencer;

  logic        clk;
  logic        i_reset;
  logic        req_w [2];
  logic [1:0]  i_sel;
  logic        i_RW;
  logic [14:0] i_addr;
  logic [7:0]  i_wdata;
  logic [7:0]  i_dq;

  logic [14:0] addr_w  [2];
  logic [7:0]  dq_w    [2];
  logic        oe_w    [2];
  logic        we_w    [2];
  logic        re_w    [2];
  logic [1:0]  ce_w    [2];
  logic [1:0]  ce2_w   [2];
  logic [7:0]  rdata_w [2];
  logic        busy_w  [2];
  logic        done_w  [2];
  logic        mrdy_w  [2];
  logic        ovr_w   [2];

  int          n_vec;
  int          n_err;
  logic [7:0]  rd_model [2];
  logic [7:0]  sb_q [$];

  sram_access_sequencer u_dut_a (
    .i_clk (clk), .i_reset (i_reset), .i_req (req_w[0]), .i_sel (i_sel),
    .i_RW (i_RW), .i_addr (i_addr), .i_wdata (i_wdata), .i_dq (i_dq),
    .o_addr (addr_w[0]), .o_dq (dq_w[0]), .o_dq_oe (oe_w[0]), .o_WE (we_w[0]),
    .o_RE (re_w[0]), .o_CE (ce_w[0]), .o_CE2 (ce2_w[0]), .o_rdata (rdata_w[0]),
    .o_busy (busy_w[0]), .o_done (done_w[0]), .o_MRDY (mrdy_w[0]), .o_overrun (ovr_w[0])
  );

  sram_access_sequencer #(
    .SETUP_CYCLES (0), .PULSE_CYCLES (1), .HOLD_CYCLES (0)
  ) u_dut_b (
    .i_clk (clk), .i_reset (i_reset), .i_req (req_w[1]), .i_sel (i_sel),
    .i_RW (i_RW), .i_addr (i_addr), .i_wdata (i_wdata), .i_dq (i_dq),
    .o_addr (addr_w[1]), .o_dq (dq_w[1]), .o_dq_oe (oe_w[1]), .o_WE (we_w[1]),
    .o_RE (re_w[1]), .o_CE (ce_w[1]), .o_CE2 (ce2_w[1]), .o_rdata (rdata_w[1]),
    .o_busy (busy_w[1]), .o_done (done_w[1]), .o_MRDY (mrdy_w[1]), .o_overrun (ovr_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packed pin/status view: {CE, CE2, WE, RE, OE, busy, done, MRDY, overrun}.
  task automatic get_obs(input int which, output logic [10:0] v);
    v = {ce_w[which], ce2_w[which], we_w[which], re_w[which], oe_w[which],
         busy_w[which], done_w[which], mrdy_w[which], ovr_w[which]};
  endtask

  // Expected view in cycle c after acceptance (c = 0 means plain idle).
  function automatic logic [10:0] exp_vec(input int c, input int s, input int p, input int h,
                                          input logic rw, input int bank, input logic ov);
    int   d;
    logic busy;
    logic pul;
    logic [1:0] ce;
    d    = 1 + s + p + h;
    busy = (c >= 1) && (c < d);
    pul  = (c > s) && (c <= s + p);
    ce   = 2'b11;
    if (busy) ce[bank] = 1'b0;
    return {ce, ~ce, ~(pul & ~rw), ~(pul & rw), busy & ~rw, busy, (c == d) && (c > 0), ~busy, ov};
  endfunction

  task automatic run_access(input int which, input logic rw, input logic [1:0] sel,
                            input logic [14:0] addr, input logic [7:0] wd,
                            input logic [7:0] rd, input int inj);
    int s, p, h, d, bank;
    logic [10:0] obs;
    logic [7:0]  exp_rd;
    s    = (which == 0) ? 1 : 0;
    p    = (which == 0) ? 2 : 1;
    h    = (which == 0) ? 1 : 0;
    d    = 1 + s + p + h;
    bank = sel[0] ? 0 : 1;
    if (rw) rd_model[which] = rd;
    sb_q.push_back(rd_model[which]);
    i_RW = rw; i_sel = sel; i_addr = addr; i_wdata = wd;
    req_w[which] = 1'b1;
    tick();
    for (int c = 1; c <= d; c++) begin
      req_w[which] = (c == inj);
      i_addr  = ~addr;
      i_wdata = ~wd;
      i_dq    = (c == s + p) ? rd : ~rd;
      get_obs(which, obs);
      chk($sformatf("pins_dut%0d_c%0d", which, c), 32'(obs),
          32'(exp_vec(c, s, p, h, rw, bank, (inj > 0) && (c == inj + 1))));
      if (c == s + p) begin
        chk($sformatf("addr_dut%0d", which), 32'(addr_w[which]), 32'(addr));
        if (!rw) chk($sformatf("wdata_dut%0d", which), 32'(dq_w[which]), 32'(wd));
      end
      if (c == d) begin
        exp_rd = sb_q.pop_front();
        chk($sformatf("rdata_dut%0d", which), 32'(rdata_w[which]), 32'(exp_rd));
      end else begin
        tick();
      end
    end
    req_w[which] = 1'b0;
  endtask

  task automatic idle_cycles(input int which, input int n);
    logic [10:0] obs;
    for (int i = 0; i < n; i++) begin
      tick();
      get_obs(which, obs);
      chk($sformatf("idle_dut%0d", which), 32'(obs), 32'(exp_vec(0, 1, 2, 1, 1'b1, 0, 1'b0)));
    end
  endtask

  initial begin
    logic [10:0] obs;
    n_vec = 0; n_err = 0;
    rd_model[0] = 8'h00; rd_model[1] = 8'h00;
    i_reset = 1'b1; req_w[0] = 1'b0; req_w[1] = 1'b0;
    i_sel = 2'b00; i_RW = 1'b1; i_addr = 15'h0000; i_wdata = 8'h00; i_dq = 8'h00;
    tick();
    tick();
    for (int w = 0; w < 2; w++) begin
      get_obs(w, obs);
      chk("reset_pins", 32'(obs), 32'(exp_vec(0, 1, 2, 1, 1'b1, 0, 1'b0)));
      chk("reset_addr", 32'(addr_w[w]), 32'h0);
      chk("reset_dq", 32'(dq_w[w]), 32'h0);
      chk("reset_rdata", 32'(rdata_w[w]), 32'h0);
    end
    i_reset = 1'b0;
    tick();

    // Default timing: read bank 0, then write bank 1.
    run_access(0, 1'b1, 2'b01, 15'h1234, 8'h00, 8'hA5, 0);
    idle_cycles(0, 2);
    run_access(0, 1'b0, 2'b10, 15'h0F0F, 8'h3C, 8'h77, 0);
    idle_cycles(0, 1);

    // Both selects set, overrun during PULSE, then back-to-back in the done cycle.
    run_access(0, 1'b1, 2'b11, 15'h7FFF, 8'h00, 8'h5A, 2);
    run_access(0, 1'b0, 2'b01, 15'h0001, 8'hC3, 8'h00, 0);
    idle_cycles(0, 1);

    // No bank selected: request is ignored.
    i_sel = 2'b00; i_RW = 1'b0; req_w[0] = 1'b1;
    tick();
    req_w[0] = 1'b0;
    get_obs(0, obs);
    chk("nosel_c1", 32'(obs), 32'(exp_vec(0, 1, 2, 1, 1'b1, 0, 1'b0)));
    idle_cycles(0, 3);
    chk("nosel_rdata", 32'(rdata_w[0]), 32'(rd_model[0]));

    // Minimal timing instance.
    run_access(1, 1'b1, 2'b01, 15'h2222, 8'h00, 8'h99, 0);
    run_access(1, 1'b0, 2'b10, 15'h3333, 8'h44, 8'h00, 0);
    idle_cycles(1, 1);

    // Asynchronous reset in the middle of a write strobe.
    i_RW = 1'b0; i_sel = 2'b01; i_addr = 15'h0555; i_wdata = 8'hE7; req_w[0] = 1'b1;
    tick();
    req_w[0] = 1'b0;
    tick();
    get_obs(0, obs);
    chk("rst_pre_c2", 32'(obs), 32'(exp_vec(2, 1, 2, 1, 1'b0, 0, 1'b0)));
    #2;
    i_reset = 1'b1;
    #1;
    chk("rst_async_we", 32'(we_w[0]), 32'h1);
    chk("rst_async_ce", 32'(ce_w[0]), 32'h3);
    chk("rst_async_oe", 32'(oe_w[0]), 32'h0);
    chk("rst_async_ce2", 32'(ce2_w[0]), 32'h0);
    tick();
    i_reset = 1'b0;
    rd_model[0] = 8'h00; rd_model[1] = 8'h00;
    tick();
    get_obs(0, obs);
    chk("rst_after", 32'(obs), 32'(exp_vec(0, 1, 2, 1, 1'b1, 0, 1'b0)));
    chk("rst_after_rdata", 32'(rdata_w[0]), 32'(rd_model[0]));
    idle_cycles(0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
